// File: rtl/d8_execute_if.sv
// Issue and register-file-write bundle of the dumb8 execute stage.
// master: decode side (drives the issue fields, sees the write port).
// slave:  the execute stage itself.
`timescale 1ns/1ps
interface d8_execute_if;
    logic       start;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] dst;
    logic       busy;
    logic       w;
    logic [3:0] addr_w;
    logic [7:0] data;
    logic       done;
    logic       flag_z;
    logic       flag_c;

    modport master (
        output start, op, a, b, dst,
        input  busy, w, addr_w, data, done, flag_z, flag_c
    );

    modport slave (
        input  start, op, a, b, dst,
        output busy, w, addr_w, data, done, flag_z, flag_c
    );
endinterface

// File: rtl/d8_execute.sv
// dumb8 execute stage: single-cycle ALU plus an 8-step iterative
// multiply/divide unit, driving a registered one-cycle register file write.
`timescale 1ns/1ps
module d8_execute (
    input  logic          sys_clk,
    input  logic          sys_rst,
    d8_execute_if.slave   bus
);
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [2:0]  count_q, count_d;
    logic [3:0]  op_q, op_d;
    logic [3:0]  dst_q, dst_d;
    logic [7:0]  opa_q, opa_d;      // multiplicand / dividend (quotient shifts in)
    logic [7:0]  opb_q, opb_d;      // multiplier (shifted out MSB-first) / divisor
    logic [15:0] acc_q, acc_d;
    logic [8:0]  rem_q, rem_d;

    logic        w_q, w_d;
    logic        done_q, done_d;
    logic [3:0]  addr_w_q, addr_w_d;
    logic [7:0]  data_q, data_d;
    logic        flag_z_q, flag_z_d;
    logic        flag_c_q, flag_c_d;

    logic        issue_multi;
    logic        is_mul_q;
    logic [8:0]  sum9;
    logic [7:0]  alu_res;
    logic        alu_c;
    logic [15:0] acc_step;
    logic [9:0]  div_trial;
    logic        div_ge;
    logic [8:0]  rem_step;
    logic [7:0]  quo_step;
    logic [7:0]  multi_res;
    logic        multi_c;

    // ops 8..11 go to the iterative unit
    assign issue_multi = (bus.op[3:2] == 2'b10);
    assign is_mul_q    = (op_q[3:1] == 3'b100);

    // Single-cycle ALU result and carry from the live issue operands
    always_comb begin
        sum9    = {1'b0, bus.a} + {1'b0, bus.b};
        alu_res = 8'd0;
        alu_c   = 1'b0;
        case (bus.op)
            4'd0: begin alu_res = sum9[7:0];            alu_c = sum9[8];        end
            4'd1: begin alu_res = bus.a - bus.b;        alu_c = (bus.a < bus.b); end
            4'd2: alu_res = bus.a & bus.b;
            4'd3: alu_res = bus.a | bus.b;
            4'd4: alu_res = bus.a ^ bus.b;
            4'd5: begin alu_res = {bus.a[6:0], 1'b0};   alu_c = bus.a[7];       end
            4'd6: begin alu_res = {1'b0, bus.a[7:1]};   alu_c = bus.a[0];       end
            4'd7: alu_res = bus.b;
            default: begin alu_res = 8'd0;              alu_c = 1'b0;           end
        endcase
    end

    // One shift-add / restoring shift-subtract step, and the final result
    // that the count=7 step would produce
    always_comb begin
        acc_step  = (acc_q << 1) + (opb_q[7] ? {8'd0, opa_q} : 16'd0);
        // remainder never exceeds 2*divisor-1, so the 9-bit register is enough;
        // with a zero divisor every step subtracts nothing, giving 0xFF / a
        div_trial = {rem_q, opa_q[7]};
        div_ge    = (div_trial >= {2'b00, opb_q});
        rem_step  = div_ge ? 9'(div_trial - {2'b00, opb_q}) : 9'(div_trial);
        quo_step  = {opa_q[6:0], div_ge};
        case (op_q)
            4'd8:    begin multi_res = acc_step[7:0];  multi_c = |acc_step[15:8];    end
            4'd9:    begin multi_res = acc_step[15:8]; multi_c = 1'b0;               end
            4'd10:   begin multi_res = quo_step;       multi_c = (opb_q == 8'd0);    end
            default: begin multi_res = rem_step[7:0];  multi_c = (opb_q == 8'd0);    end
        endcase
    end

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next state: enter RUN on a multi-cycle issue, leave after the 8th step
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start && issue_multi) state_d = S_RUN;
            S_RUN:   if (count_q == 3'd7)          state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered write-port values
    always_comb begin
        count_d  = count_q;
        op_d     = op_q;
        dst_d    = dst_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        w_d      = 1'b0;
        done_d   = 1'b0;
        addr_w_d = addr_w_q;
        data_d   = data_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (issue_multi) begin
                        op_d    = bus.op;
                        dst_d   = bus.dst;
                        opa_d   = bus.a;
                        opb_d   = bus.b;
                        acc_d   = 16'd0;
                        rem_d   = 9'd0;
                        count_d = 3'd0;
                    end else if (!bus.op[3]) begin
                        w_d      = 1'b1;
                        done_d   = 1'b1;
                        addr_w_d = bus.dst;
                        data_d   = alu_res;
                        flag_z_d = (alu_res == 8'd0);
                        flag_c_d = alu_c;
                    end else begin
                        // NOP: completion only, write port and flags untouched
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (is_mul_q) begin
                    acc_d = acc_step;
                    opb_d = opb_q << 1;
                end else begin
                    rem_d = rem_step;
                    opa_d = quo_step;
                end
                count_d = count_q + 3'd1;
                if (count_q == 3'd7) begin
                    w_d      = 1'b1;
                    done_d   = 1'b1;
                    addr_w_d = dst_q;
                    data_d   = multi_res;
                    flag_z_d = (multi_res == 8'd0);
                    flag_c_d = multi_c;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            count_q  <= 3'd0;
            op_q     <= 4'd0;
            dst_q    <= 4'd0;
            opa_q    <= 8'd0;
            opb_q    <= 8'd0;
            acc_q    <= 16'd0;
            rem_q    <= 9'd0;
            w_q      <= 1'b0;
            done_q   <= 1'b0;
            addr_w_q <= 4'd0;
            data_q   <= 8'd0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            w_q      <= w_d;
            done_q   <= done_d;
            addr_w_q <= addr_w_d;
            data_q   <= data_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end

    assign bus.busy   = (state_q == S_RUN);
    assign bus.w      = w_q;
    assign bus.done   = done_q;
    assign bus.addr_w = addr_w_q;
    assign bus.data   = data_q;
    assign bus.flag_z = flag_z_q;
    assign bus.flag_c = flag_c_q;
endmodule

// File: tb/tb_d8_execute.sv
// Bench for d8_execute: directed test-plan cases with literal expectations,
// then random issue traffic, all checked every cycle against an
// arithmetic reference model.
`timescale 1ns/1ps
module tb_d8_execute;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    d8_execute_if bus();

    d8_execute dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // reference model state
    int         run_left = 0;
    logic [7:0] pend_data = 8'd0;
    logic [3:0] pend_addr = 4'd0;
    logic       pend_c = 1'b0;
    logic       m_busy = 1'b0, m_w = 1'b0, m_done = 1'b0, m_z = 1'b0, m_c = 1'b0;
    logic [7:0] m_data = 8'd0;
    logic [3:0] m_addr = 4'd0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // plain-arithmetic result of one instruction
    function automatic void ref_op(input int op, input int ia, input int ib,
                                   output logic [7:0] r, output logic c);
        int s;
        s = 0; r = 8'd0; c = 1'b0;
        case (op)
            0:  begin s = ia + ib; r = 8'(s % 256); c = (s > 255); end
            1:  begin r = 8'((ia - ib + 256) % 256); c = (ia < ib); end
            2:  r = 8'(ia & ib);
            3:  r = 8'(ia | ib);
            4:  r = 8'(ia ^ ib);
            5:  begin r = 8'((ia * 2) % 256); c = (ia >= 128); end
            6:  begin r = 8'(ia / 2); c = (ia % 2 == 1); end
            7:  r = 8'(ib);
            8:  begin s = ia * ib; r = 8'(s % 256); c = (s >= 256); end
            9:  begin s = ia * ib; r = 8'(s / 256); end
            10: if (ib == 0) begin r = 8'hFF; c = 1'b1; end else r = 8'(ia / ib);
            11: if (ib == 0) begin r = 8'(ia); c = 1'b1; end else r = 8'(ia % ib);
            default: ;
        endcase
    endfunction

    // advance the model by one rising edge with the inputs sampled there
    task automatic model_edge(input bit rst, input bit st, input int op,
                              input int ia, input int ib, input int d);
        logic [7:0] r;
        logic       c;
        if (rst) begin
            run_left = 0; m_w = 0; m_done = 0; m_data = 0; m_addr = 0; m_z = 0; m_c = 0;
        end else begin
            m_w = 0; m_done = 0;
            if (run_left > 0) begin
                run_left--;
                if (run_left == 0) begin
                    m_w = 1; m_done = 1; m_data = pend_data; m_addr = pend_addr;
                    m_c = pend_c; m_z = (pend_data == 8'd0);
                end
            end else if (st) begin
                ref_op(op, ia, ib, r, c);
                if (op < 8) begin
                    m_w = 1; m_done = 1; m_data = r; m_addr = 4'(d);
                    m_c = c; m_z = (r == 8'd0);
                end else if (op >= 12) begin
                    m_done = 1;
                end else begin
                    run_left = 8; pend_data = r; pend_addr = 4'(d); pend_c = c;
                end
            end
        end
        m_busy = (run_left > 0);
    endtask

    // one clock: drive, rising edge, model, then sit at the falling edge
    task automatic step(input bit rst, input bit st, input int op,
                        input int ia, input int ib, input int d);
        sys_rst   = rst;
        bus.start = st;
        bus.op    = 4'(op);
        bus.a     = 8'(ia);
        bus.b     = 8'(ib);
        bus.dst   = 4'(d);
        @(posedge sys_clk);
        model_edge(rst, st, op, ia, ib, d);
        chk_en = 1'b1;
        @(negedge sys_clk);
        cyc++;
    endtask

    // every-cycle comparison of all outputs against the model
    always @(negedge sys_clk) begin
        if (chk_en) begin
            check("busy",   16'(bus.busy),   16'(m_busy));
            check("w",      16'(bus.w),      16'(m_w));
            check("done",   16'(bus.done),   16'(m_done));
            check("data",   16'(bus.data),   16'(m_data));
            check("addr_w", 16'(bus.addr_w), 16'(m_addr));
            check("flag_z", 16'(bus.flag_z), 16'(m_z));
            check("flag_c", 16'(bus.flag_c), 16'(m_c));
        end
    end

    // issue one op, wait (bounded) for its write, check literal expectations
    task automatic directed(input string name, input int op, input int ia, input int ib,
                            input int d, input int exp_data, input int exp_c,
                            input int exp_z, input int exp_lat, input int exp_busy);
        int lat;
        int busy_n;
        step(0, 1, op, ia, ib, d);
        lat = 1;
        busy_n = 0;
        while (!bus.w && lat < 12) begin
            if (bus.busy) busy_n++;
            step(0, 0, 0, 0, 0, 0);
            lat++;
        end
        check({name, "_w"},      16'(bus.w),      16'd1);
        check({name, "_lat"},    16'(lat),        16'(exp_lat));
        check({name, "_busycy"}, 16'(busy_n),     16'(exp_busy));
        check({name, "_data"},   16'(bus.data),   16'(exp_data));
        check({name, "_addr"},   16'(bus.addr_w), 16'(d));
        check({name, "_c"},      16'(bus.flag_c), 16'(exp_c));
        check({name, "_z"},      16'(bus.flag_z), 16'(exp_z));
        step(0, 0, 0, 0, 0, 0);
        check({name, "_wdrop"},  16'(bus.w),      16'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int op, ia, ib;
        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.dst = 0;

        // reset and idle
        step(1, 1, 0, 8'hF0, 8'h20, 3);
        step(1, 0, 0, 0, 0, 0);
        check("rst_outputs", {bus.busy, bus.w, bus.done, bus.addr_w, bus.data, bus.flag_z, bus.flag_c},
              16'd0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 8'h55, 8'hAA, 7);
            if (bus.w) n++;
        end
        check("idle_no_w", 16'(n), 16'd0);

        // ALU sweep and the multiply/divide cases
        directed("add",  0, 8'hF0, 8'h20, 3, 8'h10, 1, 0, 1, 0);
        directed("sub",  1, 8'h05, 8'h05, 4, 8'h00, 0, 1, 1, 0);
        directed("shr",  6, 8'h01, 8'h00, 2, 8'h00, 1, 1, 1, 0);
        directed("mull", 8, 8'h12, 8'h34, 9, 8'hA8, 1, 0, 9, 8);
        directed("mulh", 9, 8'h12, 8'h34, 10, 8'h03, 0, 0, 9, 8);
        directed("div",  10, 200, 7, 11, 8'h1C, 0, 0, 9, 8);
        directed("mod",  11, 200, 7, 12, 8'h04, 0, 0, 9, 8);
        directed("div0", 10, 9, 0, 13, 8'hFF, 1, 0, 9, 8);
        directed("mod0", 11, 9, 0, 14, 8'h09, 1, 0, 9, 8);

        // NOP: done only
        step(0, 1, 13, 1, 2, 5);
        check("nop_done", 16'(bus.done), 16'd1);
        check("nop_w",    16'(bus.w),    16'd0);
        check("nop_addr", 16'(bus.addr_w), 16'd14);

        // stall: MUL then ADD held every cycle, accepted after the MUL write
        step(0, 1, 8, 8'h12, 8'h34, 5);
        n = 1;
        do begin
            step(0, 1, 0, 8'h11, 8'h22, 6);
            n++;
        end while (!(bus.w && bus.addr_w == 4'd6) && n < 15);
        check("stall_lat",  16'(n),        16'd10);
        check("stall_data", 16'(bus.data), 16'h33);
        step(0, 0, 0, 0, 0, 0);

        // reset in the middle of a divide
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 10, 9, 0, 8);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("abort_busy", 16'(bus.busy), 16'd0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0, 0, 0);
            if (bus.w) n++;
        end
        check("abort_no_w",  16'(n), 16'd0);
        check("abort_flags", {14'd0, bus.flag_z, bus.flag_c}, 16'd0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            op = int'($urandom_range(0, 15));
            ia = int'($urandom_range(0, 255));
            ib = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) != 0),
                 op, ia, ib, int'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
